// File: rtl/cpu_gpr_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_gpr_dump_pkg
// Purpose  : Shared CPU definitions for the GPR dump engine: register-file
//            geometry, register-bus widths and dump FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_gpr_dump_pkg;

    localparam int c_REG_NUM    = 32;
    localparam int c_REG_ADDR_W = 5;
    localparam int c_WORD_W     = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } gpr_dump_state_t;

endpackage : cpu_gpr_dump_pkg
`default_nettype wire

// File: rtl/cpu_gpr_dump.sv
`default_nettype none
// ============================================================================
// Module   : cpu_gpr_dump
// Purpose  : Walks a (possibly wrapping) GPR address range through a shared
//            read port and streams each register out on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_gpr_dump
    import cpu_gpr_dump_pkg::*;
#(
    parameter int REG_NUM    = c_REG_NUM,
    parameter int REG_ADDR_W = c_REG_ADDR_W,
    parameter int WORD_W     = c_WORD_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] first_addr,
    input  logic [REG_ADDR_W-1:0] last_addr,
    input  logic                  abort,
    input  logic                  gnt,
    output logic                  req,
    output logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0]     rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_addr,
    output logic [WORD_W-1:0]     out_data,
    output logic                  busy,
    output logic                  done
);

    gpr_dump_state_t       r_state;
    gpr_dump_state_t       w_state_nxt;
    logic [REG_ADDR_W-1:0] r_counter;
    logic [REG_ADDR_W-1:0] r_last;
    logic                  r_out_valid;
    logic [REG_ADDR_W-1:0] r_out_addr;
    logic [WORD_W-1:0]     r_out_data;
    logic [REG_ADDR_W-1:0] w_counter_inc;
    logic                  w_at_last;

    // Explicit wrap keeps the scan correct for non-power-of-two register files
    assign w_counter_inc = (r_counter == REG_ADDR_W'(REG_NUM - 1)) ? '0 : r_counter + 1'b1;
    assign w_at_last     = (r_counter == r_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_READ;
            end
            S_READ: begin
                if (abort)    w_state_nxt = S_DONE;
                else if (gnt) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                // An abort coinciding with a handshake still counts the word as delivered
                if (abort)          w_state_nxt = S_DONE;
                else if (out_ready) w_state_nxt = w_at_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter   <= '0;
            r_last      <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_counter <= first_addr;
                        r_last    <= last_addr;
                    end
                end
                S_READ: begin
                    if (!abort && gnt) begin
                        r_out_data  <= rd_data;
                        r_out_addr  <= r_counter;
                        r_out_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (!w_at_last) r_counter <= w_counter_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req       = (r_state == S_READ);
    assign rd_addr   = r_counter;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule : cpu_gpr_dump
`default_nettype wire

// File: tb/tb_cpu_gpr_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_gpr_dump
// Purpose  : Directed self-checking bench for cpu_gpr_dump with a queue model
//            of the expected address stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_gpr_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        abort;
    logic        gnt;
    logic        req;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] gpr [32];
    int          exp_q[$];
    int          log_addr[$];
    logic [31:0] log_data[$];
    int          total = 0;
    int          bad   = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;
    assign rd_data = gpr[rd_addr];

    cpu_gpr_dump dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .abort      (abort),
        .gnt        (gnt),
        .req        (req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected scan: first, first+1, ... modulo 32, stopping at last
    task automatic load_model(input int f, input int l);
        int a;
        exp_q.delete();
        a = f;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(a);
            if (a == l) break;
            a = (a + 1) % 32;
        end
    endtask

    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [4:0]  prev_addr  = '0;
    logic [31:0] prev_data  = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (out_valid && prev_valid && !prev_hs) begin
                check("hold_addr", 32'(out_addr), 32'(prev_addr));
                check("hold_data", out_data, prev_data);
            end
            if (req) begin
                if (exp_q.size() == 0) check("req_unexpected", 32'(req), 32'd0);
                else                   check("rd_addr", 32'(rd_addr), 32'(exp_q[0]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("word_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("out_addr", 32'(out_addr), 32'(e));
                    check("out_data", out_data, gpr[e]);
                end
                log_addr.push_back(32'(out_addr));
                log_data.push_back(out_data);
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            prev_addr  = out_addr;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input int f, input int l);
        first_addr = 5'(f);
        last_addr  = 5'(l);
        load_model(f, l);
        log_addr.delete();
        log_data.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            if (done) begin
                n = i;
                return;
            end
            tick();
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_word(input int k);
        for (int i = 0; i < 200; i++) begin
            if (log_addr.size() == k && out_valid) return;
            tick();
        end
        check("word_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int d0;
        int wrap_exp [4];
        int rs_exp [3];
        wrap_exp = '{30, 31, 0, 1};
        rs_exp   = '{2, 3, 4};
        for (int i = 0; i < 32; i++) gpr[i] = 32'h1000 + 32'(i);
        reset = 1'b1; start = 1'b0; abort = 1'b0; gnt = 1'b1; out_ready = 1'b1;
        first_addr = '0; last_addr = '0;
        tick(); tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // Range scan 0..3 at full throughput
        d0 = done_cnt;
        start_dump(0, 3);
        wait_done(n);
        check("t1_done_cycle", 32'(n), 32'd9);
        tick();
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_count", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check("t1_log_addr", 32'(log_addr[i]), 32'(i));
            check("t1_log_data", log_data[i], 32'h1000 + 32'(i));
        end

        // Wrap-around scan 30..1
        d0 = done_cnt;
        start_dump(30, 1);
        wait_done(n);
        tick();
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t2_count", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++)
            check("t2_log_addr", 32'(log_addr[i]), 32'(wrap_exp[i]));

        // Backpressure on word 2
        d0 = done_cnt;
        start_dump(0, 5);
        wait_word(2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1;
        wait_done(n);
        tick();
        check("t3_count", 32'(log_addr.size()), 32'd6);
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Grant stall with a register update before the grant
        gnt = 1'b0;
        start_dump(5, 6);
        for (int i = 0; i < 3; i++) begin
            check("t4_req_hold", 32'(req), 32'd1);
            check("t4_addr_hold", 32'(rd_addr), 32'd5);
            if (i == 1) gpr[5] = 32'hCAFE_0005;
            tick();
        end
        gnt = 1'b1;
        wait_done(n);
        tick();
        check("t4_count", 32'(log_addr.size()), 32'd2);
        if (log_data.size() > 0) check("t4_stall_data", log_data[0], 32'hCAFE_0005);

        // Abort in SEND without handshake
        d0 = done_cnt;
        start_dump(10, 15);
        wait_word(1);
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check("t5_valid_drop", 32'(out_valid), 32'd0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_req", 32'(req), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("t5_count", 32'(log_addr.size()), 32'd1);
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t5_idle", 32'(busy), 32'd0);

        // Reset while in READ, then a clean scan
        d0 = done_cnt;
        gnt = 1'b0;
        start_dump(2, 4);
        check("t6_in_read", 32'(req), 32'd1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("t6_req", 32'(req), 32'd0);
        check("t6_rd_addr", 32'(rd_addr), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_addr", 32'(out_addr), 32'd0);
        check("t6_out_data", out_data, 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        gnt = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        start_dump(2, 4);
        wait_done(n);
        tick();
        check("t6_count", 32'(log_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_addr.size(); i++)
            check("t6_log_addr", 32'(log_addr[i]), 32'(rs_exp[i]));
        check("t6_done_pulses", 32'(done_cnt - d0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cpu_gpr_dump
`default_nettype wire

// File: doc/cpu_gpr_dump.md
CPU_GPR_DUMP -- requirements
Module: cpu_gpr_dump

Interface
REQ-001 Parameter: REG_NUM, 32, number of general registers scanned.
REQ-002 Parameter: REG_ADDR_W, 5, register address width.
REQ-003 Parameter: WORD_W, 32, register data width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  dump request; sampled only in IDLE.
REQ-007 first_addr  in  REG_ADDR_W  first register of the range; latched on accepted start.
REQ-008 last_addr  in  REG_ADDR_W  last register of the range; latched on accepted start.
REQ-009 abort  in  1  terminates the dump at the next edge.
REQ-010 gnt  in  1  pipeline grants the GPR read port this cycle.
REQ-011 req  out  1  read-port request to the pipeline.
REQ-012 rd_addr  out  REG_ADDR_W  address driven to the GPR read port.
REQ-013 rd_data  in  WORD_W  combinational GPR read data for rd_addr.
REQ-014 out_valid  out  1  out_addr/out_data hold a captured register.
REQ-015 out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-016 out_addr  out  REG_ADDR_W  index of the captured register.
REQ-017 out_data  out  WORD_W  captured register value.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when a dump ends, normally or by abort.

Function
REQ-020 States: IDLE, READ, SEND, DONE.
REQ-021 IDLE: start=1 latches first/last, loads the address counter with first_addr, and moves to READ.
REQ-022 READ: req=1 and rd_addr=counter; on gnt=1, capture rd_data and counter into out_data/out_addr, set out_valid, and go to SEND.
REQ-023 Capture latency: data is in out_data one cycle after the gnt cycle.
REQ-024 READ with gnt=0: hold; req stays high and rd_addr stays stable.
REQ-025 SEND: out_valid, out_addr and out_data stay stable until the handshake completes.
REQ-026 SEND on handshake, counter!=last: increment the counter modulo REG_NUM, clear out_valid, and return to READ.
REQ-027 SEND on handshake, counter==last: clear out_valid and go to DONE.
REQ-028 Wrap-around: last<first scans first..REG_NUM-1, then 0..last.
REQ-029 first==last dumps exactly one register; a full scan is first=k, last=(k-1) mod REG_NUM.
REQ-030 DONE: done=1 for one cycle, then go to IDLE.
REQ-031 abort=1 in READ or SEND: next state is DONE, out_valid and req are cleared, and no further handshake occurs.
REQ-032 abort in the same cycle as a SEND handshake: the word counts as delivered and the next state is DONE.
REQ-033 start asserted outside IDLE is ignored; the block does not queue it.
REQ-034 The block never writes the GPR and drives no write-port signals.
REQ-035 Throughput: at most one word per 2 cycles; zero stall cycles when gnt and out_ready are held high.

Reset
REQ-036 reset=1 forces IDLE asynchronously.
REQ-037 Reset values: req=0, rd_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, counter=0.
REQ-038 Reset mid-dump discards all progress; no done pulse is produced.

Structure
REQ-039 State encoding and REG_NUM/width constants reside in the shared CPU definitions header alongside the register-bus widths.
REQ-040 Single flat module; no sub-module required.

Verification
REQ-041 Range scan: GPR r(i)=0x1000+i, first=0, last=3, gnt=1, out_ready=1 -> 4 words with addr 0..3 and data 0x1000..0x1003; done at cycle 9 after start; busy low at cycle 10.
REQ-042 Wrap scan: first=30, last=1 -> out_addr sequence 30, 31, 0, 1, then one done pulse.
REQ-043 Backpressure: out_ready low 5 cycles on word 2 -> out_data/out_addr stable throughout; no word lost or duplicated.
REQ-044 Grant stall: gnt low 3 cycles in READ -> req high and rd_addr constant; the captured value matches the GPR content at the gnt cycle.
REQ-045 Abort in SEND without handshake -> out_valid drops at the next edge, done pulses, and the remaining addresses are never requested.
REQ-046 Reset asserted in READ -> all outputs reach reset values immediately with no done pulse; a new start after reset runs a clean scan.
